// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier.
//   - state_e : controller states (IDLE, CALC, DONE)
//   - OP_*    : operation encodings on the Op input (2'b11 is reserved and runs as MUL)
//   - XLEN    : register-file data width
//   - CNT_W   : iteration counter width
//   - absVal  : two's-complement magnitude helper used by the signed variant
package mult_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_SMULH = 2'b10;

  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] absVal(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_core.sv
// Datapath of the shift-add multiplier: 2*WIDTH accumulator, multiplicand and
// multiplier registers, one radix-2 step per cycle, final optional negate.
// Optional feature macro: SEQ_MULTIPLIER_MULH_EN (sign/magnitude handling + negate).
// Ports:
//   Clk, Reset_n  clock, asynchronous active-low reset
//   load          capture operands, clear accumulator
//   step          perform one add/shift iteration
//   isSigned      operands are signed (only meaningful with load)
//   opA, opB      multiplicand, multiplier
//   prodNext      product as it will be after the current step (sign applied)
module mult_core
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 isSigned,
  input  logic [WIDTH-1:0]     opA,
  input  logic [WIDTH-1:0]     opB,
  output logic [2*WIDTH-1:0]   prodNext
);

  logic [2*WIDTH-1:0] accQ, accD;
  logic [WIDTH-1:0]   mcandQ, mplierQ;
  logic [WIDTH:0]     upperSum;

  // Add into the upper half with the carry landing in the bit that the shift
  // moves back into the accumulator's MSB.
  always_comb begin
    upperSum = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (mplierQ[0] ? {1'b0, mcandQ} : '0);
    accD     = {upperSum, accQ[WIDTH-1:1]};
  end

`ifdef SEQ_MULTIPLIER_MULH_EN
  logic negQ;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      accQ    <= '0;
      mcandQ  <= '0;
      mplierQ <= '0;
      negQ    <= 1'b0;
    end else if (load) begin
      accQ    <= '0;
      mcandQ  <= isSigned ? absVal(opA) : opA;
      mplierQ <= isSigned ? absVal(opB) : opB;
      negQ    <= isSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
    end else if (step) begin
      accQ    <= accD;
      mplierQ <= mplierQ >> 1;
    end
  end

  assign prodNext = negQ ? (~accD + (2*WIDTH)'(1)) : accD;
`else
  logic unusedSigned;
  assign unusedSigned = isSigned;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      accQ    <= '0;
      mcandQ  <= '0;
      mplierQ <= '0;
    end else if (load) begin
      accQ    <= '0;
      mcandQ  <= opA;
      mplierQ <= opB;
    end else if (step) begin
      accQ    <= accD;
      mplierQ <= mplierQ >> 1;
    end
  end

  assign prodNext = accD;
`endif

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier beside the execute-stage ALU. Takes the two
// register-file read buses and a destination register, produces a one-cycle
// write-back packet after WIDTH iterations (66 cycles per result).
// Optional feature macro: SEQ_MULTIPLIER_MULH_EN enables UMULH/SMULH; without it
// every request is MUL and BusW is always the low half.
// Ports:
//   Clk, Reset_n   clock, asynchronous active-low reset
//   Start          request, sampled only in IDLE
//   Op             00 MUL, 01 UMULH, 10 SMULH, 11 MUL
//   BusA, BusB     multiplicand, multiplier
//   RdIn           destination register
//   Busy           high in CALC and DONE
//   BusW, RW       write-back data / address, hold after DONE
//   RegWr          one-cycle write strobe
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [4:0]       RdIn,
  output logic             Busy,
  output logic [WIDTH-1:0] BusW,
  output logic [4:0]       RW,
  output logic             RegWr
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  state_e             stateQ;
  logic [CNT_W-1:0]   cntQ;
  logic [4:0]         rdQ;
  logic               load, step, isSigned;
  logic [2*WIDTH-1:0] prodNext;
  logic [WIDTH-1:0]   result;

  assign load = (stateQ == IDLE) && Start;
  assign step = (stateQ == CALC);

`ifdef SEQ_MULTIPLIER_MULH_EN
  logic [1:0] opQ;

  assign isSigned = (Op == OP_SMULH);
  assign result   = ((opQ == OP_UMULH) || (opQ == OP_SMULH)) ?
                    prodNext[2*WIDTH-1:WIDTH] : prodNext[WIDTH-1:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      opQ <= OP_MUL;
    end else if (load) begin
      opQ <= Op;
    end
  end
`else
  logic unusedOp, unusedHi;

  assign isSigned = 1'b0;
  assign result   = prodNext[WIDTH-1:0];
  assign unusedOp = ^Op;
  assign unusedHi = ^prodNext[2*WIDTH-1:WIDTH];
`endif

  mult_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (load),
    .step     (step),
    .isSigned (isSigned),
    .opA      (BusA),
    .opB      (BusB),
    .prodNext (prodNext)
  );

  // Outputs are registered; BusW is taken from the core's post-step value so the
  // strobe and data appear together right after the last iteration.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      rdQ    <= '0;
      Busy   <= 1'b0;
      RegWr  <= 1'b0;
      BusW   <= '0;
      RW     <= '0;
    end else begin
      unique case (stateQ)
        IDLE: begin
          if (Start) begin
            stateQ <= CALC;
            cntQ   <= '0;
            rdQ    <= RdIn;
            Busy   <= 1'b1;
          end
        end
        CALC: begin
          cntQ <= cntQ + CNT_W'(1);
          if (cntQ == LastIter) begin
            stateQ <= DONE;
            RegWr  <= 1'b1;
            BusW   <= result;
            RW     <= rdQ;
          end
        end
        DONE: begin
          stateQ <= IDLE;
          RegWr  <= 1'b0;
          Busy   <= 1'b0;
        end
        default: begin
          stateQ <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: accepted requests push the expected
// write-back packet and strobe edge; a negedge monitor pops on every RegWr.
module tb_seq_multiplier;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  Op;
  logic [63:0] BusA, BusB;
  logic [4:0]  RdIn;
  logic        Busy;
  logic [63:0] BusW;
  logic [4:0]  RW;
  logic        RegWr;

  seq_multiplier #(
    .WIDTH(64)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .Op      (Op),
    .BusA    (BusA),
    .BusB    (BusB),
    .RdIn    (RdIn),
    .Busy    (Busy),
    .BusW    (BusW),
    .RW      (RW),
    .RegWr   (RegWr)
  );

  typedef struct {
    logic [63:0] busW;
    logic [4:0]  rw;
    int          edgeAt;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   edgeNo  = 0;
  bit   chkBusyLow = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) edgeNo++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: plain full-width arithmetic, high or low half picked by Op.
  function automatic logic [63:0] refMul(logic [1:0] op, logic [63:0] a, logic [63:0] b);
    logic [127:0] u, s;
    u = {64'd0, a} * {64'd0, b};
    s = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
`ifdef SEQ_MULTIPLIER_MULH_EN
    case (op)
      2'b01:   return u[127:64];
      2'b10:   return s[127:64];
      default: return u[63:0];
    endcase
`else
    if (op == 2'b11) return u[63:0];
    return u[63:0] + s[63:0] - s[63:0];
`endif
  endfunction

  // Monitor
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (chkBusyLow) begin
        check("busy_falls_after_done", {63'd0, Busy}, 64'd0);
        chkBusyLow = 0;
      end
      if (RegWr) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected_regwr: got BusW=0x%0h RW=%0d, expected no strobe", BusW, RW);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          check("busw", BusW, e.busW);
          check("rw", {59'd0, RW}, {59'd0, e.rw});
          check("strobe_edge", 64'(edgeNo), 64'(e.edgeAt));
          check("busy_in_done", {63'd0, Busy}, 64'd1);
          chkBusyLow = 1;
        end
      end
    end
  end

  task automatic waitEdge(input int target);
    while (edgeNo < target) @(negedge Clk);
  endtask

  // Issue a request once the block is idle; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, output int accEdge);
    int   n;
    exp_t e;
    n = 0;
    while (Busy && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 200) begin
      nChecks++;
      nFails++;
      $display("FAIL idle_timeout: got Busy=1 after 200 cycles, expected idle");
    end
    Start   = 1'b1;
    Op      = op;
    BusA    = a;
    BusB    = b;
    RdIn    = rd;
    accEdge = edgeNo + 1;
    e.busW  = refMul(op, a, b);
    e.rw    = rd;
    e.edgeAt = accEdge + 64;
    sbQ.push_back(e);
    @(negedge Clk);
    Start = 1'b0;
    check("busy_after_accept", {63'd0, Busy}, 64'd1);
    // Scramble buses to prove operands were captured at acceptance.
    BusA = {$urandom, $urandom};
    BusB = {$urandom, $urandom};
    RdIn = 5'($urandom);
    Op   = 2'($urandom);
  endtask

  initial begin
    int e0, n;
    logic [63:0] a, b;

    Reset_n = 1'b0;
    Start   = 1'b1;
    Op      = 2'b00;
    BusA    = 64'd3;
    BusB    = 64'd5;
    RdIn    = 5'd2;

    // Reset held with Start asserted: nothing accepted, outputs zero.
    repeat (4) begin
      @(negedge Clk);
      check("rst_busy", {63'd0, Busy}, 64'd0);
      check("rst_regwr", {63'd0, RegWr}, 64'd0);
      check("rst_busw", BusW, 64'd0);
      check("rst_rw", {59'd0, RW}, 64'd0);
    end
    Start   = 1'b0;
    Reset_n = 1'b1;
    @(negedge Clk);
    check("no_accept_in_reset", {63'd0, Busy}, 64'd0);

    // Directed cases
    issue(2'b00, 64'd3, 64'd5, 5'd2, e0);
    issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, e0);
    issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, e0);
    issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, e0);
    issue(2'b10, -64'sd3, -64'sd5, 5'd8, e0);
    issue(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd9, e0);
    issue(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd31, e0);

    // Ignored requests at E10 and E65 must not be executed.
    issue(2'b00, 64'd7, 64'd9, 5'd4, e0);
    waitEdge(e0 + 9);
    Start = 1'b1; BusA = 64'd2; BusB = 64'd2; RdIn = 5'd5; Op = 2'b00;
    @(negedge Clk);
    Start = 1'b0;
    waitEdge(e0 + 64);
    Start = 1'b1; BusA = 64'd2; BusB = 64'd2; RdIn = 5'd5;
    @(negedge Clk);
    Start = 1'b0;
    waitEdge(e0 + 70);
    check("busw_holds", BusW, 64'd63);
    check("rw_holds", {59'd0, RW}, 64'd4);
    check("ignored_not_run", {63'd0, Busy}, 64'd0);

    // Abort mid-CALC
    issue(2'b00, 64'd7, 64'd9, 5'd4, e0);
    waitEdge(e0 + 29);
    #1 Reset_n = 1'b0;
    sbQ.delete();
    #1;
    check("abort_busy", {63'd0, Busy}, 64'd0);
    check("abort_regwr", {63'd0, RegWr}, 64'd0);
    check("abort_busw", BusW, 64'd0);
    check("abort_rw", {59'd0, RW}, 64'd0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (70) begin
      @(negedge Clk);
      if (RegWr) check("abort_no_regwr", {63'd0, RegWr}, 64'd0);
    end
    issue(2'b00, 64'd6, 64'd7, 5'd1, e0);

    // Randomized traffic
    for (int i = 0; i < 25; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = 64'hFFFF_FFFF_FFFF_FFFF;
        1: b = 64'h8000_0000_0000_0000;
        2: a = 64'd0;
        default: ;
      endcase
      issue(2'($urandom), a, b, 5'($urandom), e0);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end

    // Drain
    n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("scoreboard_drained", 64'(sbQ.size()), 64'd0);
    repeat (3) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative 64-bit shift-add multiplier that sits beside the ALU in the execute stage. It consumes the two register-file read buses (BusA, BusB) and the destination register number, computes the product over multiple cycles, and produces a one-cycle write-back packet (BusW, RW, RegWr) that drives the register file's write port. It implements LEGv8 MUL; the high-half variants are optional.

## Interface
- WIDTH, 64, operand and result width (register file data width)
- Clk  input  1  clock; all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  request; sampled only in IDLE
- Op  input  2  00 MUL, 01 UMULH, 10 SMULH, 11 reserved (treated as MUL)
- BusA  input  WIDTH  multiplicand (register-file read bus A)
- BusB  input  WIDTH  multiplier (register-file read bus B)
- RdIn  input  5  destination register number
- Busy  output  1  high while CALC or DONE
- BusW  output  WIDTH  result to register-file write data
- RW  output  5  destination register to register-file write address
- RegWr  output  1  one-cycle write strobe (= done)

## Operation
- States: IDLE, CALC, DONE.
- IDLE: Start=1 at a rising edge latches BusA, BusB, Op, and RdIn; clears the 128-bit product accumulator and the iteration counter; goes to CALC.
- Signed op (SMULH): latch the operand magnitudes plus a sign flag (signA XOR signB). The unsigned product is negated (two's complement, 128 bits) before output.
- CALC: one iteration per cycle, radix-2. If multiplier bit[0]=1, add the multiplicand into the upper half of the accumulator with carry out into bit 128. Then shift the accumulator right by 1. After WIDTH iterations, go to DONE.
- DONE: RegWr=1, BusW = low WIDTH bits (MUL) or high WIDTH bits (UMULH/SMULH), RW = latched RdIn; next edge returns to IDLE.
- Arithmetic is modulo 2^(2·WIDTH); MUL truncates silently, with no overflow flag.
- RW=31 is still strobed; the register file discards XZR writes.
- Start while Busy is ignored and not queued. The bus values of an ignored Start are not captured.
- Operands are captured at acceptance, so later changes on BusA, BusB, or RdIn do not affect the result.

## Timing
- Reset (async, immediate): state=IDLE; Busy=0, RegWr=0, BusW=0, RW=0; accumulator and counter cleared.
- Start accepted at edge E0 → CALC from E0; iterations at edges E1..E64 → DONE after E64.
- RegWr=1 for exactly the one cycle between E64 and E65. BusW and RW are stable for that whole cycle, so the register file's negedge write captures them.
- Back-to-back: earliest next acceptance is E66, because Start at E65 sees DONE and is ignored. Throughput is one result per 66 cycles.
- BusW and RW hold their last value after DONE; RegWr is the only validity qualifier.
- Reset_n asserted mid-CALC or in DONE aborts the operation with no RegWr. After release, the block is ready in IDLE on the next edge.

## Configuration
- SEQ_MULTIPLIER_MULH_EN defined: Op decoded fully; UMULH and SMULH return the high half, with sign handling as above.
- Not defined: Op is ignored and every operation is MUL. The sign/magnitude logic and the negation are removed. BusW is always the low WIDTH bits.

## Structure
- Shared package mult_pkg holds:
  - state enum (IDLE, CALC, DONE)
  - Op encodings (OP_MUL, OP_UMULH, OP_SMULH)
  - XLEN=64
  - counter width $clog2(XLEN)+1
- One sub-module, mult_core: accumulator, add/shift step, and final negate. It takes a load/step control from the FSM in seq_multiplier, which owns the state, counter, latched RdIn/Op, and outputs.

## Test plan
- Reset: hold Reset_n=0 with Start=1 → Busy=0, RegWr=0, BusW=0, RW=0 throughout; no acceptance.
- MUL 3×5, RdIn=2: Start at E0 → RegWr=1 only between E64 and E65, BusW=15, RW=2; Busy falls after E65.
- MUL wrap: 0xFFFF_FFFF_FFFF_FFFF × 2 → BusW=0xFFFF_FFFF_FFFF_FFFE.
- With SEQ_MULTIPLIER_MULH_EN, same operands:
  - UMULH → BusW=1.
  - SMULH (−1)×2 → BusW=0xFFFF_FFFF_FFFF_FFFF.
  - SMULH (−3)×(−5) → BusW=0.
- Ignored request: start 7×9 (RdIn=4), then pulse Start with 2×2 (RdIn=5) at E10 and at E65 → a single RegWr with BusW=63, RW=4; the second request is not executed.
- Abort: start 7×9, drive Reset_n=0 at cycle 30 → outputs zero immediately, no RegWr ever. After release, 6×7 (RdIn=1) → BusW=42, RW=1, 64 cycles after acceptance.
